// File: rtl/rx_word_aligner.sv
// Receive word aligner: finds the K28.5 comma in the raw deserialized stream and re-frames it.
// Optional misaligned-comma counter enabled by defining HBWIF_ALIGNER_ERR_COUNT_EN.
module rx_word_aligner #(
  parameter int unsigned LOCK_COUNT   = 4,
  parameter int unsigned UNLOCK_COUNT = 3,
  parameter int unsigned ERR_WIDTH    = 16
) (
  input  logic                 slowClk,
  input  logic                 resetIn,
  input  logic [9:0]           data_rx,
  input  logic                 enable,
  output logic [9:0]           data_out,
  output logic                 data_valid,
  output logic                 comma,
  output logic                 locked,
  output logic [3:0]           offset,
  output logic                 realign
`ifdef HBWIF_ALIGNER_ERR_COUNT_EN
  ,
  output logic [ERR_WIDTH-1:0] err_count
`endif
);

  localparam int unsigned WORD_W = 10;
  localparam int unsigned WIN_W  = 2 * WORD_W;
  localparam int unsigned OFF_W  = 4;
  localparam int unsigned HIT_W  = $clog2(LOCK_COUNT + 1);
  localparam int unsigned MISS_W = $clog2(UNLOCK_COUNT + 1);

  localparam logic [WORD_W-1:0] COMMA_NEG = 10'b0011111010;
  localparam logic [WORD_W-1:0] COMMA_POS = 10'b1100000101;

  if (LOCK_COUNT < 1 || UNLOCK_COUNT < 1 || ERR_WIDTH < 1) begin : g_bad_params
    $error("rx_word_aligner: LOCK_COUNT, UNLOCK_COUNT and ERR_WIDTH must be at least 1");
  end

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [WORD_W-1:0]   cur_q, prev_q;
  logic [OFF_W-1:0]    cand_q, cand_d;
  logic [OFF_W-1:0]    off_q, off_d;
  logic [HIT_W-1:0]    hit_q, hit_d;
  logic [MISS_W-1:0]   miss_q, miss_d;
  logic [WIN_W-1:0]    window;
  logic [WORD_W-1:0]   match;
  logic [WORD_W-1:0]   cand_word;
  logic                hit;
  logic [OFF_W-1:0]    hit_off;
  logic [4:0]          shamt;
  logic [WORD_W-1:0]   out_word;
  logic                out_is_comma;

  assign window = {prev_q, cur_q};

  // Comma search over all ten bit offsets; lowest offset wins.
  always_comb begin
    match     = '0;
    cand_word = '0;
    hit       = 1'b0;
    hit_off   = '0;
    for (int k = 0; k < 10; k++) begin
      cand_word = WORD_W'(window >> (10 - k));
      match[k]  = (cand_word == COMMA_NEG) || (cand_word == COMMA_POS);
    end
    for (int k = 9; k >= 0; k--) begin
      if (match[k]) begin
        hit     = 1'b1;
        hit_off = OFF_W'(k);
      end
    end
  end

  // Next-state logic for the hunt/verify/locked alignment FSM.
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    off_d   = off_q;
    hit_d   = hit_q;
    miss_d  = miss_q;
    if (enable && hit) begin
      unique case (state_q)
        HUNT: begin
          cand_d = hit_off;
          hit_d  = HIT_W'(1);
          if (LOCK_COUNT == 1) begin
            state_d = LOCKED;
            off_d   = hit_off;
            miss_d  = '0;
          end else begin
            state_d = VERIFY;
          end
        end
        VERIFY: begin
          if (hit_off == cand_q) begin
            hit_d = hit_q + HIT_W'(1);
            if (32'(hit_q) + 32'd1 >= LOCK_COUNT) begin
              state_d = LOCKED;
              off_d   = cand_q;
              miss_d  = '0;
            end
          end else begin
            cand_d = hit_off;
            hit_d  = HIT_W'(1);
          end
        end
        LOCKED: begin
          if (hit_off == off_q) begin
            miss_d = '0;
          end else if (32'(miss_q) + 32'd1 >= UNLOCK_COUNT) begin
            state_d = HUNT;
            miss_d  = '0;
          end else begin
            miss_d = miss_q + MISS_W'(1);
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  // The output follows the offset being entered, so the locking comma is emitted as valid.
  always_comb begin
    shamt        = 5'(WORD_W) - 5'(off_d);
    out_word     = WORD_W'(window >> shamt);
    out_is_comma = (out_word == COMMA_NEG) || (out_word == COMMA_POS);
  end

  always_ff @(posedge slowClk) begin
    if (resetIn) begin
      state_q    <= HUNT;
      cur_q      <= '0;
      prev_q     <= '0;
      cand_q     <= '0;
      off_q      <= '0;
      hit_q      <= '0;
      miss_q     <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      comma      <= 1'b0;
      locked     <= 1'b0;
      realign    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_q      <= data_rx;
      prev_q     <= cur_q;
      cand_q     <= cand_d;
      off_q      <= off_d;
      hit_q      <= hit_d;
      miss_q     <= miss_d;
      data_out   <= out_word;
      data_valid <= (state_d == LOCKED);
      comma      <= (state_d == LOCKED) && out_is_comma;
      locked     <= (state_d == LOCKED);
      realign    <= (state_d == LOCKED) && (state_q != LOCKED);
    end
  end

  assign offset = off_q;

`ifdef HBWIF_ALIGNER_ERR_COUNT_EN
  logic [ERR_WIDTH-1:0] err_q, err_d;

  // Saturating count of commas seen at the wrong offset while locked.
  always_comb begin
    err_d = err_q;
    if (enable && (state_q == LOCKED) && hit && (hit_off != off_q) && (err_q != '1)) begin
      err_d = err_q + ERR_WIDTH'(1);
    end
  end

  always_ff @(posedge slowClk) begin
    if (resetIn) begin
      err_q <= '0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_count = err_q;
`endif

endmodule

// File: tb/tb_rx_word_aligner.sv
// Bench for rx_word_aligner: bit-stream stimulus, per-cycle reference model and directed checks.
module tb_rx_word_aligner;

  localparam int unsigned LOCK_COUNT   = 4;
  localparam int unsigned UNLOCK_COUNT = 3;
  localparam int unsigned ERR_WIDTH    = 16;

  localparam logic [9:0] K_NEG = 10'b0011111010;
  localparam logic [9:0] K_POS = 10'b1100000101;
  // Fillers with short runs: they can never form a comma at any offset.
  localparam logic [9:0] FILL [5] = '{10'b1010101010, 10'b0101010101, 10'b1001100110,
                                      10'b0110011001, 10'b1101001011};

  logic                 slowClk = 1'b0;
  logic                 resetIn = 1'b1;
  logic                 enable  = 1'b1;
  logic [9:0]           data_rx = '0;
  logic [9:0]           data_out;
  logic                 data_valid, comma, locked, realign;
  logic [3:0]           offset;
  logic [ERR_WIDTH-1:0] err_count;

  int checks = 0;
  int errors = 0;

  rx_word_aligner #(
    .LOCK_COUNT  (LOCK_COUNT),
    .UNLOCK_COUNT(UNLOCK_COUNT),
    .ERR_WIDTH   (ERR_WIDTH)
  ) dut (
    .slowClk   (slowClk),
    .resetIn   (resetIn),
    .data_rx   (data_rx),
    .enable    (enable),
    .data_out  (data_out),
    .data_valid(data_valid),
    .comma     (comma),
    .locked    (locked),
    .offset    (offset),
`ifdef HBWIF_ALIGNER_ERR_COUNT_EN
    .realign   (realign),
    .err_count (err_count)
`else
    .realign   (realign)
`endif
  );

`ifndef HBWIF_ALIGNER_ERR_COUNT_EN
  assign err_count = '0;
`endif

  always #5 slowClk = ~slowClk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic is_k(input logic [9:0] w);
    return (w == K_NEG) || (w == K_POS);
  endfunction

  function automatic logic [9:0] word_at(input logic [19:0] w, input int k);
    logic [19:0] s;
    s = w >> (10 - k);
    return s[9:0];
  endfunction

  function automatic int first_comma(input logic [19:0] w);
    for (int k = 0; k < 10; k++) if (is_k(word_at(w, k))) return k;
    return -1;
  endfunction

  // Reference model: mode 0 searching, 1 counting repeats, 2 aligned.
  int         m_mode, m_cand, m_hits, m_miss, m_off, m_err;
  logic [9:0] m_prev, m_cur;
  logic       m_valid = 1'b0;
  logic [9:0] exp_data;
  logic       exp_locked, exp_comma, exp_realign;
  int         exp_off;

  always @(posedge slowClk) begin
    int k, nmode, noff;
    if (resetIn) begin
      m_mode = 0; m_cand = 0; m_hits = 0; m_miss = 0; m_off = 0; m_err = 0;
      m_prev = '0; m_cur = '0;
      exp_data = '0; exp_locked = 0; exp_comma = 0; exp_realign = 0; exp_off = 0;
      m_valid = 1'b1;
    end else begin
      k     = first_comma({m_prev, m_cur});
      nmode = m_mode;
      noff  = m_off;
      if (enable && k >= 0) begin
        if (m_mode == 0) begin
          m_cand = k; m_hits = 1;
          if (LOCK_COUNT == 1) begin nmode = 2; noff = k; m_miss = 0; end
          else nmode = 1;
        end else if (m_mode == 1) begin
          if (k == m_cand) begin
            m_hits++;
            if (m_hits >= int'(LOCK_COUNT)) begin nmode = 2; noff = m_cand; m_miss = 0; end
          end else begin
            m_cand = k; m_hits = 1;
          end
        end else begin
          if (k == m_off) m_miss = 0;
          else begin
            if (m_err < (1 << ERR_WIDTH) - 1) m_err++;
            m_miss++;
            if (m_miss >= int'(UNLOCK_COUNT)) begin nmode = 0; m_miss = 0; end
          end
        end
      end
      exp_data    = word_at({m_prev, m_cur}, noff);
      exp_locked  = (nmode == 2);
      exp_comma   = exp_locked && is_k(exp_data);
      exp_realign = (nmode == 2) && (m_mode != 2);
      exp_off     = noff;
      m_mode = nmode;
      m_off  = noff;
      m_prev = m_cur;
      m_cur  = data_rx;
    end
  end

  always @(negedge slowClk) begin
    if (m_valid) begin
      chk("data_out",   32'(data_out),   32'(exp_data));
      chk("data_valid", 32'(data_valid), 32'(exp_locked));
      chk("comma",      32'(comma),      32'(exp_comma));
      chk("locked",     32'(locked),     32'(exp_locked));
      chk("offset",     32'(offset),     32'(exp_off));
      chk("realign",    32'(realign),    32'(exp_realign));
`ifdef HBWIF_ALIGNER_ERR_COUNT_EN
      chk("err_count",  32'(err_count),  32'(m_err));
`endif
    end
  end

  // Stimulus: bits are queued and cut into 10-bit words, so pad bits set the phase.
  bit         bq[$];
  logic       rst_v = 1'b0;
  logic       en_v  = 1'b1;
  logic [9:0] ohist [3];

  task automatic tick(input logic [9:0] w);
    data_rx = w;
    resetIn = rst_v;
    enable  = en_v;
    @(posedge slowClk);
    #1;
  endtask

  task automatic push_bits(input int n, input logic [9:0] v);
    logic [9:0] w;
    for (int i = n - 1; i >= 0; i--) bq.push_back(v[i]);
    while (bq.size() >= 10) begin
      w = '0;
      for (int i = 0; i < 10; i++) w = {w[8:0], bq.pop_front()};
      tick(w);
    end
  endtask

  task automatic send_word(input logic [9:0] w);
    ohist[2] = ohist[1];
    ohist[1] = ohist[0];
    ohist[0] = w;
    push_bits(10, w);
  endtask

  task automatic pad(input int n);
    push_bits(n, 10'b0101010101);
  endtask

  task automatic fill();
    send_word(FILL[$urandom_range(0, 4)]);
  endtask

  // Comma preceded by fillers and followed by two, after which the FSM has acted on it.
  task automatic comma_burst(input int idx);
    repeat (5) fill();
    send_word(idx[0] ? K_POS : K_NEG);
    fill();
    fill();
  endtask

  task automatic do_reset(input int n);
    rst_v = 1'b1;
    repeat (n) tick(10'($urandom));
    rst_v = 1'b0;
    bq.delete();
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_data"},    32'(data_out),   32'd0);
    chk({tag, "_valid"},   32'(data_valid), 32'd0);
    chk({tag, "_comma"},   32'(comma),      32'd0);
    chk({tag, "_locked"},  32'(locked),     32'd0);
    chk({tag, "_offset"},  32'(offset),     32'd0);
    chk({tag, "_realign"}, 32'(realign),    32'd0);
  endtask

  task automatic follow_check(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      if (i == 3) send_word(K_POS);
      else fill();
      chk({tag, "_follow_data"},  32'(data_out), 32'(ohist[2]));
      chk({tag, "_follow_comma"}, 32'(comma),    32'(is_k(ohist[2])));
    end
  endtask

  task automatic lock_at(input int pad_bits);
    pad(pad_bits);
    for (int c = 1; c <= 4; c++) comma_burst(c);
  endtask

  initial begin
    ohist = '{default: '0};

    do_reset(3);
    chk_zero_outputs("reset");
    tick(10'($urandom));
    chk_zero_outputs("post_reset1");
    tick(10'($urandom));
    chk_zero_outputs("post_reset2");

    // Lock at offset 3, then the original words come back out.
    do_reset(2);
    pad(3);
    for (int c = 1; c <= 4; c++) begin
      comma_burst(c);
      chk("lock3_locked",  32'(locked),  32'(c == 4));
      chk("lock3_realign", 32'(realign), 32'(c == 4));
    end
    chk("lock3_offset", 32'(offset), 32'd3);
    chk("lock3_comma",  32'(comma),  32'd1);
    chk("lock3_data",   32'(data_out), 32'(K_NEG));
    fill();
    chk("lock3_realign_pulse", 32'(realign), 32'd0);
    follow_check("lock3", 8);

    // Two commas at offset 3 then commas at offset 7.
    do_reset(2);
    pad(3);
    comma_burst(0);
    comma_burst(1);
    pad(4);
    for (int c = 1; c <= 4; c++) begin
      comma_burst(c);
      chk("restart_locked", 32'(locked), 32'(c == 4));
    end
    chk("restart_offset", 32'(offset), 32'd7);

    // Loss of lock: misaligned commas at 5 interrupted by one good comma at 3.
    do_reset(2);
    lock_at(3);
    chk("lol_initial_locked", 32'(locked), 32'd1);
    pad(2);
    comma_burst(0);
    chk("lol_miss1", 32'(locked), 32'd1);
    comma_burst(1);
    chk("lol_miss2", 32'(locked), 32'd1);
    pad(8);
    comma_burst(0);
    chk("lol_good", 32'(locked), 32'd1);
    pad(2);
    for (int c = 1; c <= 3; c++) begin
      comma_burst(c);
      chk("lol_locked", 32'(locked), 32'(c < 3));
    end
    chk("lol_offset_kept", 32'(offset), 32'd3);
    chk("lol_valid", 32'(data_valid), 32'd0);
`ifdef HBWIF_ALIGNER_ERR_COUNT_EN
    chk("lol_err_count", 32'(err_count), 32'd5);
`endif

    // Enable low holds the FSM; then aligned lock, latency, and reset mid-lock.
    do_reset(2);
    en_v = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      comma_burst(c);
      chk("enable_hold_locked", 32'(locked), 32'd0);
    end
    en_v = 1'b1;
    lock_at(0);
    chk("off0_locked", 32'(locked), 32'd1);
    chk("off0_offset", 32'(offset), 32'd0);
    follow_check("off0", 8);
    rst_v = 1'b1;
    tick(10'($urandom));
    rst_v = 1'b0;
    bq.delete();
    chk_zero_outputs("mid_lock_reset");

    // Randomized stream: data, commas, phase slips, enable toggles, rare resets.
    do_reset(2);
    for (int i = 0; i < 2500; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 30) send_word(10'($urandom));
      else if (r < 40) fill();
      else if (r < 78) send_word($urandom_range(0, 1) ? K_POS : K_NEG);
      else if (r < 86) pad(int'($urandom_range(1, 9)));
      else if (r < 98) en_v = ($urandom_range(0, 3) != 0);
      else if (r == 98) begin
        rst_v = 1'b1;
        tick(10'($urandom));
        rst_v = 1'b0;
      end else begin
        en_v = 1'b1;
        for (int c = 0; c < 5; c++) comma_burst(c);
      end
    end
    en_v = 1'b1;
    repeat (4) fill();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
